// File: rtl/calc_bank.sv
// Button-driven calculator with a bank of NREGS signed accumulators and a 3-state execute FSM.
// Define CALC_UNDO_EN to add the btn_undo port and a per-accumulator circular undo history.
module calc_bank #(
  parameter int WIDTH      = 16,
  parameter int NREGS      = 4,
  parameter int UNDO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     btnu,
  input  logic                     btnl,
  input  logic                     btnc,
  input  logic                     btnr,
  input  logic                     btnd,
`ifdef CALC_UNDO_EN
  input  logic                     btn_undo,
`endif
  input  logic [$clog2(NREGS)-1:0] sel,
  input  logic [WIDTH-1:0]         sw,
  output logic [WIDTH-1:0]         led,
  output logic                     zero,
  output logic                     ovf,
  output logic                     busy
);

  localparam int SELW = $clog2(NREGS);
  localparam int SHW  = (WIDTH < 5) ? WIDTH : 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPT,
    S_WRITE
`ifdef CALC_UNDO_EN
    ,
    S_UCAPT,
    S_UWRITE
`endif
  } state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [SELW-1:0]  sel_q;
  logic [WIDTH-1:0] sw_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc [NREGS];

  logic             btnd_s1, btnd_s2, btnd_prev;
  logic [1:0]       warm;
  logic             armed;
  logic             exec;

  // Edges are only honoured once the synchroniser has refilled after reset,
  // so a button held through reset release cannot fire.
  assign armed = (warm == 2'd3);
  assign exec  = armed & btnd_s2 & ~btnd_prev;

  always_ff @(posedge clk) begin
    if (btnu) begin
      btnd_s1   <= 1'b0;
      btnd_s2   <= 1'b0;
      btnd_prev <= 1'b0;
      warm      <= 2'd0;
    end else begin
      btnd_s1   <= btnd;
      btnd_s2   <= btnd_s1;
      btnd_prev <= btnd_s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

`ifdef CALC_UNDO_EN
  localparam int PW = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
  localparam int CW = $clog2(UNDO_DEPTH + 1);

  logic [WIDTH-1:0] hist [NREGS][UNDO_DEPTH];
  logic [PW-1:0]    wp   [NREGS];
  logic [CW-1:0]    cnt  [NREGS];
  logic             undo_s1, undo_s2, undo_prev;
  logic             undo_pulse;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(UNDO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(UNDO_DEPTH - 1) : p - 1'b1;
  endfunction

  assign undo_pulse = armed & undo_s2 & ~undo_prev;

  always_ff @(posedge clk) begin
    if (btnu) begin
      undo_s1   <= 1'b0;
      undo_s2   <= 1'b0;
      undo_prev <= 1'b0;
    end else begin
      undo_s1   <= btn_undo;
      undo_s2   <= undo_s1;
      undo_prev <= undo_s2;
    end
  end
`endif

  logic [WIDTH-1:0] result;
  logic             res_ovf;
  logic [WIDTH-1:0] sum, diff;
  logic [SHW-1:0]   sh_amt;
  logic             sh_big;

  always_comb begin
    result  = '0;
    res_ovf = 1'b0;
    sum     = acc_q + sw_q;
    diff    = acc_q - sw_q;
    sh_amt  = sw_q[SHW-1:0];
    sh_big  = (32'(sh_amt) >= 32'(WIDTH));
    case (op_q)
      3'b000: begin
        result  = sum;
        res_ovf = (acc_q[WIDTH-1] == sw_q[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
      end
      3'b001: begin
        result  = diff;
        res_ovf = (acc_q[WIDTH-1] != sw_q[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);
      end
      3'b010: result = acc_q & sw_q;
      3'b011: result = acc_q | sw_q;
      3'b100: result = acc_q ^ sw_q;
      3'b101: result = sh_big ? '0 : (acc_q << sh_amt);
      3'b110: result = sh_big ? {WIDTH{acc_q[WIDTH-1]}} : WIDTH'($signed(acc_q) >>> sh_amt);
      default: result = {{(WIDTH-1){1'b0}}, ($signed(acc_q) < $signed(sw_q))};
    endcase
  end

  // Operands are frozen in CAPT; the write in WRITE only touches acc[sel_q].
  always_ff @(posedge clk) begin
    if (btnu) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
      led   <= '0;
      op_q  <= '0;
      sel_q <= '0;
      sw_q  <= '0;
      acc_q <= '0;
      for (int i = 0; i < NREGS; i++) acc[i] <= '0;
`ifdef CALC_UNDO_EN
      for (int i = 0; i < NREGS; i++) begin
        wp[i]  <= '0;
        cnt[i] <= '0;
      end
`endif
    end else begin
      led <= acc[sel];
      case (state)
        S_IDLE: begin
          if (exec) begin
            state <= S_CAPT;
            busy  <= 1'b1;
          end
`ifdef CALC_UNDO_EN
          else if (undo_pulse && cnt[sel] != '0) begin
            sel_q <= sel;
            state <= S_UCAPT;
            busy  <= 1'b1;
          end
`endif
        end
        S_CAPT: begin
          op_q  <= {btnl, btnc, btnr};
          sel_q <= sel;
          sw_q  <= sw;
          acc_q <= acc[sel];
          state <= S_WRITE;
        end
        S_WRITE: begin
          acc[sel_q] <= result;
          zero       <= (result == '0);
          ovf        <= res_ovf;
          busy       <= 1'b0;
          state      <= S_IDLE;
`ifdef CALC_UNDO_EN
          hist[sel_q][wp[sel_q]] <= acc_q;
          wp[sel_q]              <= ptr_inc(wp[sel_q]);
          if (cnt[sel_q] != CW'(UNDO_DEPTH)) cnt[sel_q] <= cnt[sel_q] + 1'b1;
`endif
        end
`ifdef CALC_UNDO_EN
        S_UCAPT: begin
          acc_q <= hist[sel_q][ptr_dec(wp[sel_q])];
          state <= S_UWRITE;
        end
        S_UWRITE: begin
          acc[sel_q] <= acc_q;
          zero       <= (acc_q == '0);
          ovf        <= 1'b0;
          wp[sel_q]  <= ptr_dec(wp[sel_q]);
          cnt[sel_q] <= cnt[sel_q] - 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
